// File: rtl/hll_pkg.sv
// hll_pkg: HyperLogLog sketch constants, pipeline types and rank helper
package hll_pkg;
  localparam int P = 14;
  localparam int REG_W = 4;
  localparam int REGS_PER_WORD = 32;
  localparam int RANK_MAX = 15;
  localparam int NIB_W = $clog2(REGS_PER_WORD);
  localparam int WORD_AW = P - NIB_W;
  localparam int WORD_W = REG_W * REGS_PER_WORD;
  localparam int RANK_BITS = RANK_MAX - 1;
  typedef enum logic [1:0] {CLEAR, UPDATE, DRAIN, STREAM} state_t;
  typedef struct packed {
    logic               v;
    logic [WORD_AW-1:0] word;
    logic [NIB_W-1:0]   nib;
    logic [REG_W-1:0]   rank;
  } op_t;
  function automatic logic [REG_W-1:0] rank_of(input logic [RANK_BITS-1:0] top);
    logic [REG_W-1:0] r;
    r = REG_W'(RANK_MAX);
    for (int i = 0; i < RANK_BITS; i++) r = top[i] ? REG_W'(RANK_BITS - i) : r;
    return r;
  endfunction
endpackage

// File: rtl/hll_sketch_ram.sv
// hll_sketch_ram: read-first sketch word RAM with one-cycle read latency
module hll_sketch_ram
  import hll_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [WORD_AW-1:0] waddr,
  input  logic [WORD_W-1:0]  wdata,
  input  logic [WORD_AW-1:0] raddr,
  output logic [WORD_W-1:0]  rdata
);
  logic [WORD_W-1:0] mem [2**WORD_AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/hll_sketch_builder.sv
// hll_sketch_builder: folds a hash stream into a P=14 HyperLogLog sketch and streams it out on flush
module hll_sketch_builder
  import hll_pkg::*;
#(
  parameter int HASH_W = 64,
  parameter int WORDS = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [HASH_W-1:0] in_hash,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [WORD_W-1:0] est_data,
  output logic              est_valid,
  output logic              done
);
  localparam logic [WORD_AW:0] CLEAR_LAST = (WORD_AW+1)'(WORDS - 1);
  localparam logic [WORD_AW:0] STREAM_END = (WORD_AW+1)'(WORDS);
  localparam logic [WORD_AW:0] CNT_ONE = (WORD_AW+1)'(1);
  state_t state_q, state_d;
  logic [WORD_AW:0] cnt_q, cnt_d;
  op_t s1_q, s1_d, s2_q, s2_d;
  logic fwd_q, fwd_d, est_valid_q, est_valid_d, done_q, done_d;
  logic [WORD_W-1:0] fwd_data_q, fwd_data_d, rdata, base, merged, wdata;
  logic [REG_W-1:0] old_nib;
  logic [WORD_AW-1:0] raddr, waddr;
  logic we, accept, zeroing, unused_mid;
  assign unused_mid = ^in_hash[HASH_W-RANK_BITS-1:P];
  assign in_ready = state_q == UPDATE && !flush;
  assign accept = in_valid && in_ready;
  assign zeroing = state_q == CLEAR || state_q == STREAM;
  assign base = fwd_q ? fwd_data_q : rdata;
  assign old_nib = base[{s2_q.nib, 2'b00} +: REG_W];
  assign raddr = state_q == STREAM ? cnt_q[WORD_AW-1:0] : s1_q.word;
  assign we = state_q == CLEAR || (state_q == STREAM && cnt_q != '0) || s2_q.v;
  assign waddr = state_q == CLEAR ? cnt_q[WORD_AW-1:0] :
                 state_q == STREAM ? cnt_q[WORD_AW-1:0] - WORD_AW'(1) : s2_q.word;
  assign wdata = zeroing ? '0 : merged;
  assign est_valid = est_valid_q;
  assign est_data = est_valid_q ? rdata : '0;
  assign done = done_q;
  always_comb begin
    merged = base;
    merged[{s2_q.nib, 2'b00} +: REG_W] = old_nib > s2_q.rank ? old_nib : s2_q.rank;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   state_d = cnt_q == CLEAR_LAST ? UPDATE : CLEAR;
      UPDATE:  state_d = flush ? DRAIN : UPDATE;
      DRAIN:   state_d = s1_q.v ? DRAIN : STREAM;
      STREAM:  state_d = cnt_q == STREAM_END ? UPDATE : STREAM;
      default: state_d = CLEAR;
    endcase
    cnt_d = state_d != state_q ? '0 : cnt_q + CNT_ONE;
    est_valid_d = state_q == STREAM && cnt_q != STREAM_END;
    done_d = state_q == STREAM && cnt_q == STREAM_END;
    s1_d.v = accept;
    s1_d.word = in_hash[P-1:NIB_W];
    s1_d.nib = in_hash[NIB_W-1:0];
    s1_d.rank = rank_of(in_hash[HASH_W-1 -: RANK_BITS]);
    s2_d = s1_q;
    fwd_d = s2_q.v && s2_q.word == s1_q.word;
    fwd_data_d = merged;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      fwd_q <= 1'b0;
      fwd_data_q <= '0;
      est_valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      fwd_q <= fwd_d;
      fwd_data_q <= fwd_data_d;
      est_valid_q <= est_valid_d;
      done_q <= done_d;
    end
  end
  hll_sketch_ram u_ram (
    .clk(clk),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_hll_sketch_builder.sv
// tb_hll_sketch_builder: random and directed stimulus checked against a register-array sketch model
module tb_hll_sketch_builder;
  logic clk, rst_n, in_valid, in_ready, flush, est_valid, done;
  logic [63:0] in_hash;
  logic [127:0] est_data;
  int total = 0;
  int passed = 0;
  int cyc = 0;
  int ready_from = 512;
  int stream_at = -1;
  int sk [16384];
  logic [127:0] snap [512];
  logic [127:0] dut_beat [512];
  hll_sketch_builder #(.HASH_W(64), .WORDS(512)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_hash(in_hash),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .flush(flush),
    .est_data(est_data),
    .est_valid(est_valid),
    .done(done)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask
  function automatic int rank_m(input logic [63:0] h);
    int r;
    r = 1;
    for (int b = 63; b >= 14; b--) begin
      if (h[b]) break;
      r++;
    end
    return r > 15 ? 15 : r;
  endfunction
  function automatic logic [63:0] rand_hash();
    logic [63:0] up;
    logic [13:0] idx;
    up = {$urandom, $urandom};
    up = up >> $urandom_range(0, 52);
    idx = $urandom_range(0, 1) ? 14'($urandom) : {9'($urandom_range(0, 3)), 5'($urandom)};
    return {up[63:14], idx};
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      ready_from = 512;
      stream_at = -1;
      foreach (sk[i]) sk[i] = 0;
    end else begin
      if (cyc >= ready_from && flush) begin
        for (int w = 0; w < 512; w++)
          for (int k = 0; k < 32; k++) snap[w][4*k +: 4] = 4'(sk[w*32+k]);
        foreach (sk[i]) sk[i] = 0;
        stream_at = cyc + 3;
        ready_from = cyc + 515;
      end else if (cyc >= ready_from && in_valid) begin
        int idx, r;
        idx = int'(in_hash[13:0]);
        r = rank_m(in_hash);
        if (r > sk[idx]) sk[idx] = r;
      end
      cyc++;
    end
  end
  always @(negedge clk) begin
    bit ev;
    int b;
    if (!rst_n) begin
      check("rst_in_ready", 128'(in_ready), 0);
      check("rst_est_valid", 128'(est_valid), 0);
      check("rst_done", 128'(done), 0);
      check("rst_est_data", est_data, 0);
    end else begin
      ev = stream_at >= 0 && cyc >= stream_at && cyc < stream_at + 512;
      check("in_ready", 128'(in_ready), 128'(cyc >= ready_from && !flush));
      check("est_valid", 128'(est_valid), 128'(ev));
      check("done", 128'(done), 128'(stream_at >= 0 && cyc == stream_at + 512));
      if (ev) begin
        b = cyc - stream_at;
        dut_beat[b] = est_data;
        check("est_data", est_data, snap[b]);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_flush(input logic with_valid, input logic [63:0] h);
    foreach (dut_beat[i]) dut_beat[i] = '1;
    in_valid = with_valid;
    in_hash = h;
    flush = 1;
    tick(1);
    in_valid = 0;
    tick(1);
    flush = 0;
    tick(99);
    flush = 1;
    tick(1);
    flush = 0;
    tick(418);
  endtask
  task automatic send_burst(input logic [63:0] hs [$]);
    in_valid = 1;
    foreach (hs[i]) begin
      in_hash = hs[i];
      tick(1);
    end
    in_valid = 0;
    tick(1);
  endtask
  task automatic rand_round(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_hash = rand_hash();
      tick(1);
    end
    in_valid = 0;
  endtask
  initial begin
    logic [63:0] hs [$];
    rst_n = 0;
    in_valid = 0;
    flush = 0;
    in_hash = '0;
    check("pin_rank_top", 128'(rank_m(64'h8000_0000_0000_0025)), 1);
    check("pin_rank_3", 128'(rank_m(64'h2000_0000_0000_0025)), 3);
    check("pin_rank_5", 128'(rank_m(64'h0800_0000_0000_0025)), 5);
    check("pin_rank_14", 128'(rank_m(64'h0004_0000_0000_0000)), 14);
    check("pin_rank_sat", 128'(rank_m(64'h0002_0000_0000_0000)), 15);
    check("pin_rank_zero", 128'(rank_m(64'h0000_0000_0000_3fff)), 15);
    tick(3);
    rst_n = 1;
    tick(100);
    flush = 1;
    tick(1);
    flush = 0;
    tick(420);
    do_flush(0, 64'h0);
    check("empty_beat0", dut_beat[0], '0);
    check("empty_beat511", dut_beat[511], '0);
    hs = '{64'h8000_0000_0000_0025};
    send_burst(hs);
    do_flush(0, 64'h0);
    check("single_beat1", dut_beat[1], 128'h0010_0000);
    check("single_beat0", dut_beat[0], '0);
    hs = '{64'h2000_0000_0000_0025, 64'h8000_0000_0000_0025, 64'h0800_0000_0000_0025};
    send_burst(hs);
    do_flush(0, 64'h0);
    check("b2b_beat1", dut_beat[1], 128'h0050_0000);
    hs = {};
    for (int k = 0; k < 32; k++) hs.push_back(64'h8000_0000_0000_0000 | 64'(32 + k));
    send_burst(hs);
    do_flush(0, 64'h0);
    check("fwd_beat1", dut_beat[1], {32{4'h1}});
    rand_round(400);
    do_flush(0, rand_hash());
    rand_round(400);
    do_flush(1, rand_hash());
    do_flush(1, 64'h4000_0000_0000_2580);
    check("flush_wins_beat300", dut_beat[300], '0);
    do_flush(0, 64'h0);
    check("cleared_beat300", dut_beat[300], '0);
    rand_round(400);
    flush = 1;
    tick(1);
    flush = 0;
    tick(202);
    #2;
    rst_n = 0;
    #1;
    check("async_rst_est_valid", 128'(est_valid), 0);
    check("async_rst_done", 128'(done), 0);
    tick(2);
    rst_n = 1;
    tick(515);
    do_flush(0, 64'h0);
    check("post_rst_beat200", dut_beat[200], '0);
    check("post_rst_beat3", dut_beat[3], '0);
    tick(5);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
